// File: rtl/pe_fft_pkg.sv
// Shared definitions for the radix-2 FFT PE control path: defaults, FSM
// encoding, the twiddle word type and the twiddle table builder.
package pe_fft_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int SHIFT_DEF  = 16;
    localparam int LOG2N_DEF  = 4;
    localparam int GAP_DEF    = 3;
    localparam int PE_LAT_DEF = 3;

    // Fixed-point scale used while evaluating the series; 2^28 keeps every
    // intermediate product inside 64 bits for angles below pi.
    localparam int     TF_FRAC   = 28;
    localparam longint TWO_PI_FX = 64'sd1686629713;   // 2*pi * 2^28

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // One twiddle entry before truncation to the datapath width.
    typedef struct packed {
        logic signed [63:0] re;
        logic signed [63:0] im;
    } tf_pair_t;

    // Convert a 2^TF_FRAC fixed-point value to 2^shift, rounding half away from zero.
    function automatic longint fx_to_q(input longint v, input int shift);
        longint mag;
        longint r;
        mag = (v < 64'sd0) ? -v : v;
        r   = ((mag <<< shift) + (64'sd1 <<< (TF_FRAC - 1))) >>> TF_FRAC;
        return (v < 64'sd0) ? -r : r;
    endfunction

    // Twiddle W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N), evaluated with integer
    // Taylor series so that it folds to a constant at elaboration time.
    function automatic tf_pair_t tf_entry(input int k, input int log2n, input int shift);
        longint   theta;
        longint   c_sum;
        longint   c_term;
        longint   s_sum;
        longint   s_term;
        longint   den;
        tf_pair_t e;
        theta  = (TWO_PI_FX * longint'(k)) >>> log2n;
        c_sum  = 64'sd1 <<< TF_FRAC;
        c_term = c_sum;
        s_sum  = theta;
        s_term = theta;
        for (int n = 1; n <= 20; n++) begin
            den    = longint'((2 * n - 1) * (2 * n));
            c_term = (c_term * theta) >>> TF_FRAC;
            c_term = (c_term * theta) >>> TF_FRAC;
            c_term = -(c_term / den);
            c_sum  = c_sum + c_term;
            den    = longint'((2 * n) * (2 * n + 1));
            s_term = (s_term * theta) >>> TF_FRAC;
            s_term = (s_term * theta) >>> TF_FRAC;
            s_term = -(s_term / den);
            s_sum  = s_sum + s_term;
        end
        e.re = fx_to_q(c_sum, shift);
        e.im = -fx_to_q(s_sum, shift);
        return e;
    endfunction

endpackage

// File: rtl/tf_rom.sv
// Combinational twiddle ROM: exponent k (0..N/2-1) -> {re, im}.
module tf_rom
    import pe_fft_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHIFT = SHIFT_DEF,
    parameter int LOG2N = LOG2N_DEF
) (
    input  logic [LOG2N-2:0]   k,
    output logic [2*WIDTH-1:0] tf
);

    localparam int HALF_N = 1 << (LOG2N - 1);

    logic [2*WIDTH-1:0] tab_s [HALF_N];

    for (genvar i = 0; i < HALF_N; i++) begin : g_tab
        localparam tf_pair_t ENTRY = tf_entry(i, LOG2N, SHIFT);
        assign tab_s[i] = {ENTRY.re[WIDTH-1:0], ENTRY.im[WIDTH-1:0]};
    end

    // Table lookup for the requested exponent.
    always_comb begin
        tf = tab_s[k];
    end

endmodule

// File: rtl/pe_tf_sequencer.sv
// Twiddle/bypass sequencer for the radix-2 butterfly PE: walks an N-point
// FFT stage by stage, with a gap between stages and a drain before done.
module pe_tf_sequencer
    import pe_fft_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int SHIFT  = SHIFT_DEF,
    parameter int LOG2N  = LOG2N_DEF,
    parameter int GAP    = GAP_DEF,
    parameter int PE_LAT = PE_LAT_DEF
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       start,
    input  logic                       hold,
    output logic                       busy,
    output logic                       done,
    output logic                       issue_valid,
    output logic [LOG2N-3:0]           issue_cnt,
    output logic [$clog2(LOG2N)-1:0]   stage,
    output logic [2*WIDTH-1:0]         tf,
    output logic                       bypass_n
);

    localparam int CW   = LOG2N - 2;
    localparam int SW   = $clog2(LOG2N);
    localparam int KW   = LOG2N - 1;
    localparam int GMAX = (GAP > PE_LAT) ? GAP : PE_LAT;
    localparam int GCW  = $clog2(GMAX + 1);

    localparam logic [CW-1:0]  C_LAST     = CW'((1 << CW) - 1);
    localparam logic [SW-1:0]  S_LAST     = SW'(LOG2N - 1);
    localparam logic [GCW-1:0] GAP_LOAD   = GCW'(GAP - 1);
    localparam logic [GCW-1:0] DRAIN_LOAD = GCW'(PE_LAT - 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      c_q, c_d;
    logic [SW-1:0]      s_q, s_d;
    logic [GCW-1:0]     g_q, g_d;
    logic [2*WIDTH-1:0] tf_q, tf_d;
    logic               byp1_q, byp1_d;
    logic               bypass_n_q, bypass_n_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               issue_s;
    logic [CW-1:0]      c_nx_s;
    logic [KW-1:0]      k_s;
    logic [2*WIDTH-1:0] rom_tf_s;

    // An issue happens in every ISSUE cycle the data source is not stalling.
    always_comb begin
        issue_s = (state_q == ST_ISSUE) && !hold;
    end

    // Exponent for the slot that follows this cycle: next c in the current
    // stage, c = 0 (k = 0) when a stage wraps or a run starts.
    always_comb begin
        if ((state_q == ST_ISSUE) && (c_q != C_LAST)) begin
            c_nx_s = c_q + 1'b1;
        end else begin
            c_nx_s = '0;
        end
        k_s = {1'b0, c_nx_s} << s_q;
        k_s = k_s << 1;
    end

    tf_rom #(
        .WIDTH (WIDTH),
        .SHIFT (SHIFT),
        .LOG2N (LOG2N)
    ) u_tf_rom (
        .k  (k_s),
        .tf (rom_tf_s)
    );

    // Next-state logic for the run FSM, counters and registered outputs.
    always_comb begin
        state_d    = state_q;
        c_d        = c_q;
        s_d        = s_q;
        g_d        = g_q;
        tf_d       = tf_q;
        done_d     = 1'b0;
        byp1_d     = issue_s && (s_q != S_LAST);
        bypass_n_d = byp1_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    c_d     = '0;
                    s_d     = '0;
                    tf_d    = rom_tf_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (!hold) begin
                    tf_d = rom_tf_s;
                    c_d  = c_nx_s;
                    if (c_q == C_LAST) begin
                        if (s_q == S_LAST) begin
                            state_d = ST_DRAIN;
                            g_d     = DRAIN_LOAD;
                        end else begin
                            state_d = ST_GAP;
                            g_d     = GAP_LOAD;
                        end
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_GAP: begin
                if (g_q == '0) begin
                    state_d = ST_ISSUE;
                    s_d     = s_q + 1'b1;
                end else begin
                    g_d = g_q - 1'b1;
                end
            end
            ST_DRAIN: begin
                if (g_q == '0) begin
                    state_d = ST_IDLE;
                    s_d     = '0;
                    done_d  = 1'b1;
                end else begin
                    g_d = g_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q    <= ST_IDLE;
            c_q        <= '0;
            s_q        <= '0;
            g_q        <= '0;
            tf_q       <= '0;
            byp1_q     <= 1'b0;
            bypass_n_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            c_q        <= c_d;
            s_q        <= s_d;
            g_q        <= g_d;
            tf_q       <= tf_d;
            byp1_q     <= byp1_d;
            bypass_n_q <= bypass_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign issue_valid = issue_s;
    assign issue_cnt   = c_q;
    assign stage       = s_q;
    assign tf          = tf_q;
    assign bypass_n    = bypass_n_q;

endmodule

// File: tb/tb_pe_tf_sequencer.sv
// Directed bench for pe_tf_sequencer at the default configuration
// (N=16, GAP=3, PE_LAT=3). Cycle t is the clock period in which inputs
// driven for t are visible; outputs are sampled on the falling edge.
module tb_pe_tf_sequencer;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        start;
    logic        hold;
    logic        busy;
    logic        done;
    logic        issue_valid;
    logic [1:0]  issue_cnt;
    logic [1:0]  stage;
    logic [63:0] tf;
    logic        bypass_n;

    int n_checks = 0;
    int n_fail   = 0;
    int cur_t    = 0;

    logic [63:0] exp_tf [4][4];
    logic [63:0] k0_v, k2_v, k4_v, k6_v;

    pe_tf_sequencer dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .start       (start),
        .hold        (hold),
        .busy        (busy),
        .done        (done),
        .issue_valid (issue_valid),
        .issue_cnt   (issue_cnt),
        .stage       (stage),
        .tf          (tf),
        .bypass_n    (bypass_n)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cur_t, act, exp);
        end
    endtask

    function automatic logic rng(input int u, input int lo, input int hi);
        return (u >= lo) && (u <= hi);
    endfunction

    // Expected outputs of an unstalled run whose start was driven in cycle 0.
    task automatic chk_base(input int u);
        logic e_iv;
        int   stg;
        int   c;
        e_iv = rng(u, 1, 4) || rng(u, 8, 11) || rng(u, 15, 18) || rng(u, 22, 25);
        chk("issue_valid", issue_valid, e_iv);
        chk("busy", busy, rng(u, 1, 28));
        chk("done", done, u == 29);
        chk("bypass_n", bypass_n, rng(u, 3, 6) || rng(u, 10, 13) || rng(u, 17, 20));
        if (e_iv) begin
            stg = (u - 1) / 7;
            c   = (u - 1) % 7;
            chk("stage", stage, stg);
            chk("issue_cnt", issue_cnt, c);
            chk("tf", tf, exp_tf[stg][c]);
        end
    endtask

    task automatic chk_zero();
        chk("zero_busy", busy, 0);
        chk("zero_done", done, 0);
        chk("zero_issue_valid", issue_valid, 0);
        chk("zero_issue_cnt", issue_cnt, 0);
        chk("zero_stage", stage, 0);
        chk("zero_tf", tf, 0);
        chk("zero_bypass_n", bypass_n, 0);
    endtask

    // scn 1: plain run; 4: hold in stage 0 and in gap; 5: start while busy
    // and on done; 6: reset mid-run.
    task automatic run_scn(input int scn, input int ncyc);
        int cnt_tab [7];
        cnt_tab = '{0, 0, 1, 1, 1, 2, 3};
        for (int t = 0; t < ncyc; t++) begin
            cur_t   = t;
            start   = (scn == 5) ? (t == 0 || t == 10 || t == 29) : (t == 0);
            hold    = (scn == 4) && (t == 2 || t == 3 || t == 7 || t == 8 || t == 9);
            Reset_n = !((scn == 6) && (t == 12));
            @(negedge Clk);
            if (scn == 4) begin
                if (t <= 6) begin
                    chk("h_issue_valid", issue_valid, (t == 1) || rng(t, 4, 6));
                    chk("h_busy", busy, t >= 1);
                    chk("h_done", done, 0);
                    chk("h_bypass_n", bypass_n, (t == 3) || (t == 6));
                    if (t >= 1) begin
                        chk("h_stage", stage, 0);
                        chk("h_issue_cnt", issue_cnt, cnt_tab[t]);
                        chk("h_tf", tf, exp_tf[0][cnt_tab[t]]);
                    end
                end else begin
                    chk_base(t - 2);
                end
            end else if (scn == 5) begin
                chk_base((t >= 30) ? t - 29 : t);
            end else if (scn == 6) begin
                if (t <= 12) begin
                    chk_base(t);
                end else begin
                    chk_zero();
                end
            end else begin
                chk_base(t);
            end
            @(posedge Clk);
            #1;
        end
        start   = 1'b0;
        hold    = 1'b0;
        Reset_n = 1'b1;
    endtask

    initial begin
        k0_v = 64'h00010000_00000000;
        k2_v = 64'h0000B505_FFFF4AFB;
        k4_v = 64'h00000000_FFFF0000;
        k6_v = 64'hFFFF4AFB_FFFF4AFB;
        exp_tf[0] = '{k0_v, k2_v, k4_v, k6_v};
        exp_tf[1] = '{k0_v, k4_v, k0_v, k4_v};
        exp_tf[2] = '{k0_v, k0_v, k0_v, k0_v};
        exp_tf[3] = '{k0_v, k0_v, k0_v, k0_v};

        Reset_n = 1'b0;
        start   = 1'b0;
        hold    = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk_zero();
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        run_scn(1, 32);
        run_scn(4, 34);
        run_scn(5, 61);
        run_scn(6, 36);
        run_scn(1, 32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
